// File: rtl/local_bias_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : local_bias_ctrl
// Description : Power sequencer and supply monitor for the multi-channel local
//               bias generator. It synchronises and debounces the supply-good
//               comparator flags, brings up the cascode bias, and then enables
//               the current-bias channels one step at a time. It latches supply
//               faults and drives the analog testbus (ATB) switch selects.
//
// Ports       : clk        - block clock
//               rst        - synchronous, active-high reset
//               pdb        - power-down bar, 0 forces OFF
//               vdd1p8_ok  - async comparator flag, 1.8 V supply in range
//               vdd0p8_ok  - async comparator flag, 0.8 V supply in range
//               vss_ok     - async comparator flag, ground in range
//               ch_en      - requested channel enables [N_CH]
//               atb_ena    - testbus request (bit0 vcas->atb0, bit1 ch->atb1)
//               atb_ch     - channel observed on atb1
//               vcas_en    - cascode bias enable
//               bias_en    - per-channel current-bias enables [N_CH]
//               atb0_en    - vcas -> atb0 switch
//               atb1_en    - channel -> atb1 switch
//               atb1_ch    - registered channel select for atb1
//               ready      - all requested channels up
//               fault      - sticky supply fault
//               state      - FSM state, for debug
//
// Revision    : 1.0 - initial release
// ============================================================================
module local_bias_ctrl #(
    parameter int  N_CH         = 4,
    parameter int  DEBOUNCE_CYC = 4,
    parameter int  SETTLE_CYC   = 8,
    parameter int  STEP_CYC     = 2,
    parameter int  FAULT_FILT   = 2,
    localparam int c_CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pdb,
    input  logic              vdd1p8_ok,
    input  logic              vdd0p8_ok,
    input  logic              vss_ok,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [1:0]        atb_ena,
    input  logic [c_CH_W-1:0] atb_ch,
    output logic              vcas_en,
    output logic [N_CH-1:0]   bias_en,
    output logic              atb0_en,
    output logic              atb1_en,
    output logic [c_CH_W-1:0] atb1_ch,
    output logic              ready,
    output logic              fault,
    output logic [2:0]        state
);

    // One shared phase counter serves debounce, settle and step timing; it
    // only ever counts up to the last cycle of the longest phase.
    localparam int c_CNT_MAX = (DEBOUNCE_CYC > SETTLE_CYC) ?
                               ((DEBOUNCE_CYC > STEP_CYC) ? DEBOUNCE_CYC : STEP_CYC) :
                               ((SETTLE_CYC > STEP_CYC) ? SETTLE_CYC : STEP_CYC);
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_FILT_W  = (FAULT_FILT > 1) ? $clog2(FAULT_FILT) : 1;

    localparam logic [c_CNT_W-1:0]  c_DEB_LAST    = c_CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0]  c_STEP_LAST   = c_CNT_W'(STEP_CYC - 1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST   = c_FILT_W'(FAULT_FILT - 1);
    localparam logic [c_CH_W-1:0]   c_IDX_LAST    = c_CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_WAIT_SUP = 3'd1,
        S_CAS_UP   = 3'd2,
        S_CH_RAMP  = 3'd3,
        S_READY    = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [c_CH_W-1:0]   r_idx;
    logic [c_CH_W-1:0]   w_idx_next;
    logic [c_FILT_W-1:0] r_filt;
    logic [c_FILT_W-1:0] w_filt_next;
    logic [N_CH-1:0]     r_bias;
    logic [N_CH-1:0]     w_bias_next;
    logic                w_sup_fail;

    logic [2:0]          r_sync_meta;
    logic [2:0]          r_sync;
    logic                w_sup_ok;

    logic                w_vcas_next;
    logic                w_atb_sel;
    logic                r_atb0;
    logic                r_atb1;
    logic [c_CH_W-1:0]   r_atb1_ch;

    // ------------------------------------------------------------------------
    // Supply flag synchronisers (2 flops per flag)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= {vss_ok, vdd0p8_ok, vdd1p8_ok};
            r_sync      <= r_sync_meta;
        end
    end

    assign w_sup_ok = &r_sync;

    // ------------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_filt_next  = '0;
        w_bias_next  = r_bias;
        w_sup_fail   = 1'b0;

        // Fault filter: only consecutive bad samples count, one good sample
        // clears it. Outside the powered states it is held at zero.
        if ((r_state == S_CAS_UP) || (r_state == S_CH_RAMP) || (r_state == S_READY)) begin
            if (!w_sup_ok) begin
                if (r_filt == c_FILT_LAST) begin
                    w_sup_fail = 1'b1;
                end else begin
                    w_filt_next = r_filt + c_FILT_W'(1);
                end
            end
        end

        if (!pdb) begin
            w_state_next = S_OFF;
            w_cnt_next   = '0;
            w_idx_next   = '0;
            w_filt_next  = '0;
            w_bias_next  = '0;
        end else if (w_sup_fail) begin
            w_state_next = S_FAULT;
            w_cnt_next   = '0;
            w_idx_next   = '0;
            w_filt_next  = '0;
            w_bias_next  = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_next = S_WAIT_SUP;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_bias_next  = '0;
                end
                S_WAIT_SUP: begin
                    // A supply drop here only restarts the debounce window.
                    if (w_sup_ok) begin
                        if (r_cnt == c_DEB_LAST) begin
                            w_state_next = S_CAS_UP;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + c_CNT_W'(1);
                        end
                    end else begin
                        w_cnt_next = '0;
                    end
                end
                S_CAS_UP: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        w_state_next   = S_CH_RAMP;
                        w_cnt_next     = '0;
                        w_idx_next     = '0;
                        w_bias_next[0] = ch_en[0];
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
                S_CH_RAMP: begin
                    // Each channel owns one step even when not requested, so
                    // ramp duration is independent of ch_en.
                    if (r_cnt == c_STEP_LAST) begin
                        w_cnt_next = '0;
                        if (r_idx == c_IDX_LAST) begin
                            w_state_next = S_READY;
                        end else begin
                            w_idx_next = r_idx + c_CH_W'(1);
                            for (int i = 0; i < N_CH; i++) begin
                                if (w_idx_next == c_CH_W'(i)) begin
                                    w_bias_next[i] = ch_en[i];
                                end
                            end
                        end
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
                S_READY: begin
                    w_bias_next = ch_en;
                end
                S_FAULT: begin
                    w_bias_next = '0;
                end
                default: begin
                    w_state_next = S_OFF;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_bias_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_filt  <= '0;
            r_bias  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_filt  <= w_filt_next;
            r_bias  <= w_bias_next;
        end
    end

    // ------------------------------------------------------------------------
    // ATB switch selects
    // ------------------------------------------------------------------------
    // The switches are qualified with the enables that will be live after this
    // edge, so an ATB path never stays closed once its bias source turns off
    // (FAULT entry, pdb low). Requests still take one register stage.
    assign w_vcas_next = (w_state_next == S_CAS_UP) ||
                         (w_state_next == S_CH_RAMP) ||
                         (w_state_next == S_READY);

    // An out-of-range atb_ch matches no channel and leaves the switch open.
    always_comb begin
        w_atb_sel = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (atb_ch == c_CH_W'(i)) begin
                w_atb_sel = w_bias_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_atb0    <= 1'b0;
            r_atb1    <= 1'b0;
            r_atb1_ch <= '0;
        end else begin
            r_atb0    <= atb_ena[0] & w_vcas_next;
            r_atb1    <= atb_ena[1] & w_atb_sel;
            r_atb1_ch <= (w_state_next == S_OFF) ? '0 : atb_ch;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign vcas_en = (r_state == S_CAS_UP) || (r_state == S_CH_RAMP) || (r_state == S_READY);
    assign bias_en = r_bias;
    assign ready   = (r_state == S_READY);
    assign fault   = (r_state == S_FAULT);
    assign state   = r_state;
    assign atb0_en = r_atb0;
    assign atb1_en = r_atb1;
    assign atb1_ch = r_atb1_ch;

endmodule
`default_nettype wire

// File: doc/local_bias_ctrl.md
# local_bias_ctrl

Digital sequencer and monitor for the parametrised, multi-channel local bias generator. It debounces supply-good comparator flags and sequences the cascode bias. It then enables N_CH current-bias channels one at a time, latches supply faults, and drives the analog-testbus (ATB) routing selects. It sits between the block-level power controller (pdb, channel enables) and the analog bias macro, whose enable pins it drives directly.

## Interface
Parameters:
- N_CH, 4: number of current-bias channels (1..16)
- DEBOUNCE_CYC, 4: consecutive supply-good cycles required before power-up (≥1)
- SETTLE_CYC, 8: cycles vcas is held alone before the first channel is enabled (≥1)
- STEP_CYC, 2: cycles between successive channel enables (≥1)
- FAULT_FILT, 2: consecutive supply-bad cycles that declare a fault (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  block clock
- rst  in  1  synchronous, active-high reset
- pdb  in  1  power-down bar; 0 forces OFF
- vdd1p8_ok  in  1  async comparator flag, 1.8 V supply in range
- vdd0p8_ok  in  1  async comparator flag, 0.8 V supply in range
- vss_ok  in  1  async comparator flag, ground in range
- ch_en  in  N_CH  requested channel enables
- atb_ena  in  2  testbus request: bit0 routes vcas to atb0, bit1 routes channel atb_ch to atb1
- atb_ch  in  clog2(N_CH) (min 1)  channel observed on atb1
- vcas_en  out  1  cascode bias enable
- bias_en  out  N_CH  per-channel current-bias enables
- atb0_en  out  1  vcas→atb0 switch
- atb1_en  out  1  channel→atb1 switch
- atb1_ch  out  clog2(N_CH)  registered channel select for atb1
- ready  out  1  all requested channels up
- fault  out  1  sticky supply fault
- state  out  3  FSM state, for debug

## Operation
- Supply path: each *_ok flag passes through its own 2-flop synchronizer. sup_ok = AND of the three synchronized flags.
- FSM states, in encoding order: OFF(0), WAIT_SUP(1), CAS_UP(2), CH_RAMP(3), READY(4), FAULT(5).
- Priority on every edge: rst > pdb=0 (→OFF) > fault detect > normal transition.
- OFF: all outputs 0, counters cleared. When pdb=1 → WAIT_SUP.
- WAIT_SUP: cnt increments when sup_ok=1 and clears to 0 when sup_ok=0. When sup_ok=1 and cnt=DEBOUNCE_CYC-1 → CAS_UP.
- CAS_UP: vcas_en=1. After SETTLE_CYC cycles → CH_RAMP.
- CH_RAMP: an index k starts at 0 and advances every STEP_CYC cycles. On entering step k, bias_en[k] takes ch_en[k]. After N_CH steps → READY. A channel with ch_en=0 still consumes its step.
- READY: ready=1. bias_en follows ch_en with a 1-cycle register delay. vcas_en stays 1.
- Fault detect, active in CAS_UP, CH_RAMP and READY: sup_ok=0 for FAULT_FILT consecutive cycles → FAULT.
- FAULT: vcas_en, bias_en, ready and ATB enables all 0. fault=1 and holds until pdb=0; exit only to OFF.
- Supply loss in WAIT_SUP only restarts the debounce; it does not raise a fault.
- ATB:
  - atb0_en = atb_ena[0] & vcas_en.
  - atb1_en = atb_ena[1] & bias_en[atb_ch].
  - atb1_ch = atb_ch.
  - All three are registered, so each lags its inputs by 1 cycle.
  - atb_ch ≥ N_CH forces atb1_en=0.
- ch_en changes during CH_RAMP are sampled only at each channel's step. Already-enabled channels do not follow ch_en until READY.

## Timing
- Reset values: all outputs 0, state=OFF, all counters and synchronizers 0.
- Synchronizer latency is 2 cycles, from a flag edge to sup_ok.
- The examples below use the defaults with supplies already good. pdb is first sampled at 1 on edge 0.
  - WAIT_SUP at edge 1; CAS_UP at edge 5, vcas_en=1.
  - CH_RAMP at edge 13, bias_en[0]=1.
  - bias_en[1] at 15, bias_en[2] at 17, bias_en[3] at 19.
  - READY and ready=1 at edge 21.
- Generally: READY = 1 + DEBOUNCE_CYC + SETTLE_CYC + N_CH·STEP_CYC edges after pdb is sampled high.
- pdb=0: state=OFF and all outputs 0 on the next edge, from any state including FAULT.
- Fault latency: FAULT_FILT edges after sup_ok first samples 0, i.e. 2+FAULT_FILT after the raw flag falls.
- A single-cycle sup_ok glitch with FAULT_FILT ≥ 2 resets the filter counter and causes no fault.

## Test plan
- Nominal power-up: defaults, flags high, ch_en=4'b1111, pdb rises → vcas_en at edge 5; bias_en bits at 13/15/17/19; ready at 21.
- Partial enable: ch_en=4'b0101 → bias_en=0101 and ready at edge 21. In READY, set ch_en=4'b1111 → bias_en=1111 one cycle later.
- Debounce: vdd0p8_ok pulses low for 1 cycle during WAIT_SUP → CAS_UP delayed by the restarted count. A 1-cycle drop in READY → no fault.
- Fault: in READY drop vss_ok for 5 cycles → FAULT with all enables 0 and fault=1. Restore vss_ok → fault stays 1. pdb=0 → OFF and fault=0 next edge.
- ATB: in READY set atb_ena=2'b11, atb_ch=2 → atb0_en=1, atb1_en=1, atb1_ch=2 after 1 cycle. With ch_en[2]=0 → atb1_en=0. With pdb=0 → all 0.
- Reset mid-ramp: assert rst at edge 16 → all outputs 0 next edge and state=OFF. Release with pdb=1 → full sequence restarts from WAIT_SUP.
